// File: rtl/store_buffer_if.sv
// store_buffer_if: store, load-check and data-memory signals of the store buffer.
// The slave modport is the buffer's view; master is the surrounding pipeline/memory.
interface store_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          st_valid;
   logic          st_ready;
   logic [2:0]    st_funct3;
   logic [31:0]   st_addr;
   logic [31:0]   st_wdata;
   logic          ld_valid;
   logic [31:0]   ld_addr;
   logic          ld_stall;
   logic          dmem_write;
   logic [31:0]   dmem_address;
   logic [31:0]   dmem_wdata;
   logic [3:0]    dmem_byte_enable;
   logic          dmem_resp;
   logic [CW-1:0] count;
   logic          empty;

   modport slave (
      input  st_valid, st_funct3, st_addr, st_wdata, ld_valid, ld_addr, dmem_resp,
      output st_ready, ld_stall, dmem_write, dmem_address, dmem_wdata,
             dmem_byte_enable, count, empty
   );

   modport master (
      output st_valid, st_funct3, st_addr, st_wdata, ld_valid, ld_addr, dmem_resp,
      input  st_ready, ld_stall, dmem_write, dmem_address, dmem_wdata,
             dmem_byte_enable, count, empty
   );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the store-lane shifter and data memory.
// Stores are queued with a byte enable derived from funct3/address and drained
// in order by a two-state IDLE/WRITE FSM over a write/resp handshake.
// Optional feature macro: STBUF_LOAD_CHECK_EN -- when defined, loads stall only
// on a word-address match with an occupied entry; otherwise any load stalls
// while the buffer holds data.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t        state_r;
   state_t        next_state_s;
   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic [29:0]   addr_mem_r [DEPTH];
   logic [31:0]   data_mem_r [DEPTH];
   logic [3:0]    be_mem_r   [DEPTH];
   logic          push_s;
   logic          pop_s;
   logic          st_ready_s;
   logic          empty_s;

   // Byte enable of a store from its type and the low address bits.
   function automatic logic [3:0] calc_be(input logic [2:0] funct3, input logic [1:0] lo);
      case (funct3)
         3'b000:  calc_be = 4'b0001 << lo;
         3'b001:  calc_be = 4'b0011 << {lo[1], 1'b0};
         default: calc_be = 4'b1111;
      endcase
   endfunction

   assign st_ready_s = (count_r != CW'(DEPTH));
   assign empty_s    = (count_r == {CW{1'b0}});
   assign push_s     = sb.st_valid && st_ready_s;
   assign pop_s      = (state_r == WRITE) && sb.dmem_resp;

   assign sb.st_ready = st_ready_s;
   assign sb.empty    = empty_s;
   assign sb.count    = count_r;

   // Occupancy after this cycle's push and/or pop.
   always_comb begin
      count_next_s = count_r;
      if (push_s && !pop_s) begin
         count_next_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CW'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Pointer, occupancy and drain-state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         state_r <= next_state_s;
         count_r <= count_next_s;
         if (push_s) begin
            tail_r <= tail_r + PW'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PW'(1);
         end
      end
   end

   // Entry storage: written at the tail on accept, cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem_r[i] <= 30'h0;
            data_mem_r[i] <= 32'h0;
            be_mem_r[i]   <= 4'h0;
         end
      end else if (push_s) begin
         addr_mem_r[tail_r] <= sb.st_addr[31:2];
         data_mem_r[tail_r] <= sb.st_wdata;
         be_mem_r[tail_r]   <= calc_be(sb.st_funct3, sb.st_addr[1:0]);
      end
   end

   // Drain FSM next state: leave WRITE only when the last entry completes.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               next_state_s = WRITE;
            end else begin
               next_state_s = IDLE;
            end
         end
         WRITE: begin
            if (pop_s && (count_next_s == {CW{1'b0}})) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = WRITE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Memory request presents the head entry while in WRITE, zeros otherwise.
   always_comb begin
      sb.dmem_write       = 1'b0;
      sb.dmem_address     = 32'h0;
      sb.dmem_wdata       = 32'h0;
      sb.dmem_byte_enable = 4'h0;
      if (state_r == WRITE) begin
         sb.dmem_write       = 1'b1;
         sb.dmem_address     = {addr_mem_r[head_r], 2'b00};
         sb.dmem_wdata       = data_mem_r[head_r];
         sb.dmem_byte_enable = be_mem_r[head_r];
      end else begin
         sb.dmem_write       = 1'b0;
         sb.dmem_address     = 32'h0;
         sb.dmem_wdata       = 32'h0;
         sb.dmem_byte_enable = 4'h0;
      end
   end

`ifdef STBUF_LOAD_CHECK_EN
   logic          hit_s;
   logic [PW-1:0] offset_s;

   // Word-address match against every occupied entry, head in flight included.
   always_comb begin
      hit_s    = 1'b0;
      offset_s = {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         offset_s = PW'(i) - head_r;
         if (({1'b0, offset_s} < count_r) && (addr_mem_r[i] == sb.ld_addr[31:2])) begin
            hit_s = 1'b1;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   assign sb.ld_stall = sb.ld_valid && hit_s;
`else
   assign sb.ld_stall = sb.ld_valid && !empty_s;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scenario tasks drive store_buffer; expected writes are queued
// when stores are driven and compared in order against writes seen completing.
module tb_store_buffer;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [67:0] exp_q[$];
   logic [67:0] obs_q[$];

   store_buffer_if #(.DEPTH(DEPTH)) sb_if ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record each write that will complete at the coming rising edge.
   always @(negedge clk) begin
      if (!rst && sb_if.dmem_write && sb_if.dmem_resp) begin
         obs_q.push_back({sb_if.dmem_address, sb_if.dmem_wdata, sb_if.dmem_byte_enable});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] be;
      if (f3 == 3'b000) begin
         case (a)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0010;
            2'd2:    be = 4'b0100;
            default: be = 4'b1000;
         endcase
      end else if (f3 == 3'b001) begin
         be = a[1] ? 4'b1100 : 4'b0011;
      end else begin
         be = 4'b1111;
      end
      return be;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one store for one edge; caller guarantees st_ready.
   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      sb_if.st_valid  = 1'b1;
      sb_if.st_funct3 = f3;
      sb_if.st_addr   = a;
      sb_if.st_wdata  = d;
      tick();
      sb_if.st_valid  = 1'b0;
      exp_q.push_back({a[31:2], 2'b00, d, be_model(f3, a[1:0])});
   endtask

   task automatic drain();
      sb_if.dmem_resp = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (sb_if.empty) break;
         tick();
      end
      sb_if.dmem_resp = 1'b0;
      checks++;
      if (sb_if.empty !== 1'b1) begin
         failures++;
         $display("FAIL drain_timeout: empty=%b required 1", sb_if.empty);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sb_if.ld_valid = 1'b1;
      sb_if.ld_addr  = 32'h100;
      tick();
      tick();
      checks++;
      if ({sb_if.dmem_write, sb_if.st_ready, sb_if.empty, sb_if.ld_stall} !== 4'b0110) begin
         failures++;
         $display("FAIL reset_flags: write/ready/empty/stall=%b required 0110",
                  {sb_if.dmem_write, sb_if.st_ready, sb_if.empty, sb_if.ld_stall});
      end
      checks++;
      if (sb_if.count !== 3'd0 || sb_if.dmem_address !== 32'h0) begin
         failures++;
         $display("FAIL reset_count: count=%0d addr=%h required 0/0", sb_if.count, sb_if.dmem_address);
      end
      rst = 1'b0;
      sb_if.ld_valid = 1'b0;
      tick();
   endtask

   task automatic test_single_sw();
      sb_if.dmem_resp = 1'b0;
      do_store(3'b010, 32'h0000_1004, 32'hDEADBEEF);
      checks++;
      if (sb_if.count !== 3'd1 || sb_if.dmem_write !== 1'b0) begin
         failures++;
         $display("FAIL sw_accept: count=%0d write=%b required 1/0", sb_if.count, sb_if.dmem_write);
      end
      tick();
      checks++;
      if ({sb_if.dmem_write, sb_if.dmem_address, sb_if.dmem_byte_enable, sb_if.dmem_wdata}
          !== {1'b1, 32'h0000_1004, 4'b1111, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL sw_write: write=%b addr=%h be=%b data=%h required 1/00001004/1111/deadbeef",
                  sb_if.dmem_write, sb_if.dmem_address, sb_if.dmem_byte_enable, sb_if.dmem_wdata);
      end
      tick();
      tick();
      checks++;
      if (sb_if.dmem_write !== 1'b1 || sb_if.dmem_address !== 32'h0000_1004) begin
         failures++;
         $display("FAIL sw_hold: write=%b addr=%h required 1/00001004", sb_if.dmem_write, sb_if.dmem_address);
      end
      sb_if.dmem_resp = 1'b1;
      tick();
      sb_if.dmem_resp = 1'b0;
      checks++;
      if (sb_if.empty !== 1'b1 || sb_if.dmem_write !== 1'b0) begin
         failures++;
         $display("FAIL sw_done: empty=%b write=%b required 1/0", sb_if.empty, sb_if.dmem_write);
      end
   endtask

   task automatic test_byte_enables();
      logic [2:0]  f3_t [4];
      logic [31:0] a_t  [4];
      logic [31:0] d_t  [4];
      logic [3:0]  be_t [4];
      f3_t = '{3'b000, 3'b001, 3'b000, 3'b111};
      a_t  = '{32'h0000_2003, 32'h0000_2003, 32'h0000_2001, 32'h0000_2002};
      d_t  = '{32'hAB00_0000, 32'h1234_0000, 32'h0000_CD00, 32'h5555_AAAA};
      be_t = '{4'b1000, 4'b1100, 4'b0010, 4'b1111};
      for (int i = 0; i < 4; i++) begin
         sb_if.dmem_resp = 1'b0;
         do_store(f3_t[i], a_t[i], d_t[i]);
         tick();
         checks++;
         if (sb_if.dmem_write !== 1'b1 || sb_if.dmem_byte_enable !== be_t[i]
             || sb_if.dmem_address !== 32'h0000_2000 || sb_if.dmem_wdata !== d_t[i]) begin
            failures++;
            $display("FAIL be_case%0d: write=%b be=%b addr=%h data=%h required 1/%b/00002000/%h",
                     i, sb_if.dmem_write, sb_if.dmem_byte_enable, sb_if.dmem_address,
                     sb_if.dmem_wdata, be_t[i], d_t[i]);
         end
         sb_if.dmem_resp = 1'b1;
         tick();
         sb_if.dmem_resp = 1'b0;
      end
   endtask

   task automatic test_full();
      sb_if.dmem_resp = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         do_store(3'b010, 32'h0000_3000 + 32'(i * 4), 32'hF000_0000 + 32'(i));
      end
      checks++;
      if (sb_if.count !== 3'd4 || sb_if.st_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_state: count=%0d ready=%b required 4/0", sb_if.count, sb_if.st_ready);
      end
      sb_if.st_valid  = 1'b1;
      sb_if.st_funct3 = 3'b010;
      sb_if.st_addr   = 32'h0000_3F00;
      sb_if.st_wdata  = 32'hBAD0_BAD0;
      tick();
      sb_if.st_valid = 1'b0;
      checks++;
      if (sb_if.count !== 3'd4) begin
         failures++;
         $display("FAIL full_reject: count=%0d required 4", sb_if.count);
      end
      sb_if.dmem_resp = 1'b1;
      tick();
      sb_if.dmem_resp = 1'b0;
      checks++;
      if (sb_if.st_ready !== 1'b1 || sb_if.count !== 3'd3) begin
         failures++;
         $display("FAIL full_resp: ready=%b count=%0d required 1/3", sb_if.st_ready, sb_if.count);
      end
      sb_if.dmem_resp = 1'b1;
      do_store(3'b010, 32'h0000_3010, 32'hF000_0010);
      sb_if.dmem_resp = 1'b0;
      checks++;
      if (sb_if.count !== 3'd3) begin
         failures++;
         $display("FAIL push_pop_same: count=%0d required 3", sb_if.count);
      end
      do_store(3'b010, 32'h0000_3014, 32'hF000_0014);
      checks++;
      if (sb_if.count !== 3'd4 || sb_if.st_ready !== 1'b0) begin
         failures++;
         $display("FAIL refill: count=%0d ready=%b required 4/0", sb_if.count, sb_if.st_ready);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int wr_cycles = 0;
      int first_c   = -1;
      int last_c    = -1;
      sb_if.dmem_resp = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc < 2 * DEPTH) begin
            sb_if.st_valid  = 1'b1;
            sb_if.st_funct3 = 3'b010;
            sb_if.st_addr   = 32'h0000_5000 + 32'(cyc * 4);
            sb_if.st_wdata  = 32'h1000_0000 + 32'(cyc);
         end else begin
            sb_if.st_valid = 1'b0;
         end
         tick();
         if (cyc < 2 * DEPTH) begin
            exp_q.push_back({32'h0000_5000 + 32'(cyc * 4), 32'h1000_0000 + 32'(cyc), 4'b1111});
         end
         if (sb_if.dmem_write) begin
            wr_cycles++;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
         end
         if (cyc >= 2 * DEPTH && sb_if.empty) break;
      end
      sb_if.st_valid  = 1'b0;
      sb_if.dmem_resp = 1'b0;
      checks++;
      if (wr_cycles != 2 * DEPTH || (last_c - first_c + 1) != 2 * DEPTH) begin
         failures++;
         $display("FAIL b2b_cycles: writes=%0d span=%0d required %0d/%0d",
                  wr_cycles, last_c - first_c + 1, 2 * DEPTH, 2 * DEPTH);
      end
      checks++;
      if (sb_if.empty !== 1'b1) begin
         failures++;
         $display("FAIL b2b_empty: empty=%b required 1", sb_if.empty);
      end
   endtask

   task automatic test_load_check();
      logic exp_other;
`ifdef STBUF_LOAD_CHECK_EN
      exp_other = 1'b0;
`else
      exp_other = 1'b1;
`endif
      sb_if.dmem_resp = 1'b0;
      do_store(3'b010, 32'h0000_0100, 32'h0101_0101);
      sb_if.ld_valid = 1'b1;
      sb_if.ld_addr  = 32'h0000_0102;
      #1;
      checks++;
      if (sb_if.ld_stall !== 1'b1) begin
         failures++;
         $display("FAIL ld_same_word: stall=%b required 1", sb_if.ld_stall);
      end
      sb_if.ld_addr = 32'h0000_0200;
      #1;
      checks++;
      if (sb_if.ld_stall !== exp_other) begin
         failures++;
         $display("FAIL ld_other_word: stall=%b required %b", sb_if.ld_stall, exp_other);
      end
      do_store(3'b000, 32'h0000_0301, 32'h0000_7700);
      sb_if.ld_addr = 32'h0000_0300;
      #1;
      checks++;
      if (sb_if.ld_stall !== 1'b1) begin
         failures++;
         $display("FAIL ld_second_entry: stall=%b required 1", sb_if.ld_stall);
      end
      sb_if.ld_valid = 1'b0;
      #1;
      checks++;
      if (sb_if.ld_stall !== 1'b0) begin
         failures++;
         $display("FAIL ld_not_valid: stall=%b required 0", sb_if.ld_stall);
      end
      drain();
      sb_if.ld_valid = 1'b1;
      sb_if.ld_addr  = 32'h0000_0100;
      #1;
      checks++;
      if (sb_if.ld_stall !== 1'b0) begin
         failures++;
         $display("FAIL ld_after_drain: stall=%b required 0", sb_if.ld_stall);
      end
      sb_if.ld_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      sb_if.dmem_resp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         do_store(3'b010, 32'h0000_6000 + 32'(i * 4), 32'h6600_0000 + 32'(i));
      end
      checks++;
      if (sb_if.dmem_write !== 1'b1 || sb_if.count !== 3'd3) begin
         failures++;
         $display("FAIL mid_pre: write=%b count=%0d required 1/3", sb_if.dmem_write, sb_if.count);
      end
      sb_if.ld_valid = 1'b1;
      sb_if.ld_addr  = 32'h0000_6000;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({sb_if.dmem_write, sb_if.st_ready, sb_if.empty, sb_if.ld_stall} !== 4'b0110
          || sb_if.count !== 3'd0) begin
         failures++;
         $display("FAIL mid_reset_flags: write/ready/empty/stall=%b count=%0d required 0110/0",
                  {sb_if.dmem_write, sb_if.st_ready, sb_if.empty, sb_if.ld_stall}, sb_if.count);
      end
      checks++;
      if ({sb_if.dmem_address, sb_if.dmem_wdata, sb_if.dmem_byte_enable} !== 68'h0) begin
         failures++;
         $display("FAIL mid_reset_bus: addr=%h data=%h be=%b required 0/0/0",
                  sb_if.dmem_address, sb_if.dmem_wdata, sb_if.dmem_byte_enable);
      end
      for (int i = 0; i < 3; i++) begin
         void'(exp_q.pop_back());
      end
      sb_if.ld_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      do_store(3'b001, 32'h0000_400A, 32'hBEEF_0000);
      tick();
      checks++;
      if (sb_if.dmem_write !== 1'b1 || sb_if.dmem_address !== 32'h0000_4008
          || sb_if.dmem_byte_enable !== 4'b1100 || sb_if.dmem_wdata !== 32'hBEEF_0000) begin
         failures++;
         $display("FAIL post_reset_store: write=%b addr=%h be=%b data=%h required 1/00004008/1100/beef0000",
                  sb_if.dmem_write, sb_if.dmem_address, sb_if.dmem_byte_enable, sb_if.dmem_wdata);
      end
      drain();
   endtask

   task automatic test_scoreboard();
      int n;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL sb_count: observed=%0d required %0d", obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL sb_write%0d: got addr=%h data=%h be=%b required addr=%h data=%h be=%b", i,
                     obs_q[i][67:36], obs_q[i][35:4], obs_q[i][3:0],
                     exp_q[i][67:36], exp_q[i][35:4], exp_q[i][3:0]);
         end
      end
   endtask

   initial begin
      checks             = 0;
      failures           = 0;
      rst                = 1'b1;
      sb_if.st_valid     = 1'b0;
      sb_if.st_funct3    = 3'b000;
      sb_if.st_addr      = 32'h0;
      sb_if.st_wdata     = 32'h0;
      sb_if.ld_valid     = 1'b0;
      sb_if.ld_addr      = 32'h0;
      sb_if.dmem_resp    = 1'b0;
      test_reset();
      test_single_sw();
      test_byte_enables();
      test_full();
      test_back_to_back();
      test_load_check();
      test_reset_mid();
      test_scoreboard();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
